// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: turns button step pulses into CPU clock-enable strobes, with sticky halt.
// Defining STEP_CLK_AUTORUN_EN adds free-running mode driven by RunSwitch.
module step_clock_ctrl #(
  parameter int RUN_DIV = 50_000_000,
  parameter int DIV_W = 26,
  parameter int CNT_W = 16
) (
  input  logic             BasysCLK,
  input  logic             Reset,
  input  logic             StepPulse,
  input  logic             RunSwitch,
  input  logic             HaltReq,
  output logic             CPUCE,
  output logic [1:0]       Mode,
  output logic             Halted,
  output logic [CNT_W-1:0] StepCount
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
  state_t state, state_n;
  logic ce_n;
`ifdef STEP_CLK_AUTORUN_EN
  logic [1:0] sync;
  logic run_s;
  logic [DIV_W-1:0] div, div_n;
  logic tc;
  assign run_s = sync[1];
  assign tc = div == DIV_W'(RUN_DIV - 1);
  // Prescaler only advances while staying in RUN; any exit or wrap returns it to 0.
  assign div_n = (state == RUN && run_s && !HaltReq && !tc) ? div + 1'b1 : '0;
  always_ff @(posedge BasysCLK)
    if (Reset) begin
      sync <= '0;
      div  <= '0;
    end else begin
      sync <= {sync[0], RunSwitch};
      div  <= div_n;
    end
`else
  logic unused_run;
  logic [DIV_W-1:0] unused_div;
  assign unused_run = RunSwitch;
  assign unused_div = DIV_W'(RUN_DIV - 1);
`endif
  always_comb begin
    state_n = state;
    ce_n = 1'b0;
    if (state != HALT && HaltReq) state_n = HALT;
    else if (state == IDLE) begin
      ce_n = StepPulse;
`ifdef STEP_CLK_AUTORUN_EN
      state_n = run_s ? RUN : IDLE;
    end else if (state == RUN) begin
      state_n = run_s ? RUN : IDLE;
      ce_n = run_s && tc;
`endif
    end
  end
  always_ff @(posedge BasysCLK)
    if (Reset) begin
      state     <= IDLE;
      CPUCE     <= 1'b0;
      Halted    <= 1'b0;
      StepCount <= '0;
    end else begin
      state     <= state_n;
      CPUCE     <= ce_n;
      Halted    <= state_n == HALT;
      StepCount <= StepCount + CNT_W'(CPUCE);
    end
  assign Mode = state;
endmodule

// File: tb/tb_step_clock_ctrl.sv
// tb_step_clock_ctrl: directed and random stimulus against a cycle-level reference model.
module tb_step_clock_ctrl;
  localparam int RUN_DIV = 4;
  localparam int DIV_W = 3;
  localparam int CNT_W = 4;
`ifdef STEP_CLK_AUTORUN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic BasysCLK = 1'b0;
  logic Reset = 1'b1, StepPulse = 1'b0, RunSwitch = 1'b0, HaltReq = 1'b0;
  logic CPUCE, Halted;
  logic [1:0] Mode;
  logic [CNT_W-1:0] StepCount;
  int n_cmp = 0, n_bad = 0, n_ce = 0;
  int m_mode = 0, m_cnt = 0, m_age = 0;
  bit m_ce = 1'b0;
  bit [1:0] m_sync = 2'b00;
  bit rs_lvl = 1'b0;

  step_clock_ctrl #(.RUN_DIV(RUN_DIV), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .BasysCLK(BasysCLK), .Reset(Reset), .StepPulse(StepPulse), .RunSwitch(RunSwitch),
    .HaltReq(HaltReq), .CPUCE(CPUCE), .Mode(Mode), .Halted(Halted), .StepCount(StepCount)
  );

  always #5 BasysCLK = ~BasysCLK;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: mode 0/1/2 = idle/run/halt; run strobes every RUN_DIV cycles counted from run entry.
  task automatic model_step(input bit rst, input bit sp, input bit rs, input bit hr);
    bit run_s;
    bit ce;
    run_s = AUTO && m_sync[1];
    ce = 1'b0;
    if (rst) begin
      m_mode = 0; m_ce = 1'b0; m_cnt = 0; m_sync = 2'b00; m_age = 0;
      return;
    end
    m_cnt = (m_cnt + int'(m_ce)) % (1 << CNT_W);
    if (m_mode != 2 && hr) m_mode = 2;
    else if (m_mode == 0) begin
      ce = sp;
      if (run_s) begin m_mode = 1; m_age = 0; end
    end else if (m_mode == 1) begin
      if (!run_s) m_mode = 0;
      else begin
        m_age++;
        ce = (m_age % RUN_DIV) == 0;
      end
    end
    m_sync = {m_sync[0], rs};
    m_ce = ce;
  endtask

  task automatic tick(input bit rst, input bit sp, input bit rs, input bit hr);
    Reset = rst; StepPulse = sp; RunSwitch = rs; HaltReq = hr;
    @(posedge BasysCLK);
    model_step(rst, sp, rs, hr);
    #1;
    n_ce += int'(CPUCE);
    check("cpuce", int'(CPUCE), int'(m_ce));
    check("mode", int'(Mode), m_mode);
    check("halted", int'(Halted), int'(m_mode == 2));
    check("count", int'(StepCount), m_cnt);
  endtask

  initial begin
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("rst_mode", int'(Mode), 0);
    check("rst_count", int'(StepCount), 0);
    n_ce = 0;
    for (int c = 2; c < 13; c++) tick(0, c == 5 || c == 6 || c == 10, 0, 0);
    check("step_strobes", n_ce, 3);
    check("step_count", int'(StepCount), 3);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
    end
    tick(0, 0, 0, 0);
    check("wrap_count", int'(StepCount), 1);
    tick(1, 0, 0, 0);
    repeat (3) tick(0, 0, 1, 0);
    check("run_entry", int'(Mode), AUTO ? 1 : 0);
    n_ce = 0;
    repeat (12) tick(0, 0, 1, 0);
    check("run_strobes", n_ce, AUTO ? 3 : 0);
    n_ce = 0;
    repeat (6) tick(0, 0, 0, 0);
    check("run_exit_strobes", n_ce, 0);
    check("run_exit_mode", int'(Mode), 0);
    repeat (6) tick(0, 0, 1, 0);
    tick(1, 0, 1, 0);
    check("rst_run_ce", int'(CPUCE), 0);
    check("rst_run_mode", int'(Mode), 0);
    check("rst_run_count", int'(StepCount), 0);
    repeat (3) tick(0, 0, 1, 0);
    check("rerun_mode", int'(Mode), AUTO ? 1 : 0);
    tick(1, 0, 0, 0);
    repeat (6) tick(0, 0, 0, 0);
    tick(0, 1, 0, 1);
    check("halt_ce", int'(CPUCE), 0);
    check("halt_flag", int'(Halted), 1);
    n_ce = 0;
    repeat (20) tick(0, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
    check("halt_strobes", n_ce, 0);
    check("halt_mode", int'(Mode), 2);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) rs_lvl = ~rs_lvl;
      tick($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, rs_lvl, $urandom_range(0, 99) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
